sha256_msg_schedule: RTL and testbench

Producer end of the SHA-256 message-word interface: accepts one 512-bit block as 16 serial 32-bit words and streams the expanded schedule W[0..ROUNDS-1], one word per handshake, to the compression round logic (the consumer of choice/majority/sigma outputs). It holds a 16-entry sliding window and computes W[t+16] on the fly. Sits between block padding/input logic and the round engine.

---
 rtl/sha256_msg_schedule.sv | 144 ++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// Purpose : SHA-256 message schedule; loads 16 words, streams W[0..ROUNDS-1] to the round logic.
// Latency : first W[0] valid the cycle after the 16th accepted input word; one word per handshake.
// Backpr. : w_ready low freezes w_out/w_index/w_last and the window; no input accepted while streaming.
//
// Ports:
//   clock              rising-edge system clock
//   reset              asynchronous active-low reset
//   flush              synchronous abort, back to LOAD (wins over both handshakes)
//   in_valid/in_ready  input word handshake; in_word is the block word (W[0] first)
//   w_valid/w_ready    schedule word handshake
//   w_out              schedule word W[w_index]
//   w_index            round index t of w_out
//   w_last             marks w_index == ROUNDS-1
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_out,
  output logic [5:0]  w_index,
  output logic        w_last
);

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  load_cnt;
  logic [5:0]  t;
  logic [31:0] win [16];
  logic        load_acc;
  logic        emit_acc;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // The window always holds W[t..t+15], so W[t+16] only needs taps at
  // fixed positions 0, 1, 9 and 14.
  assign w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  // Outputs come straight from state/counter/window registers, so there is
  // no combinational path from w_ready or in_valid to any output.
  assign in_ready = (state == LOAD);
  assign w_valid  = (state == STREAM);
  assign w_out    = win[0];
  assign w_index  = t;
  assign w_last   = (state == STREAM) && (t == LAST_T);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_acc  = 1'b0;
    emit_acc  = 1'b0;
    if (flush) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            load_acc = 1'b1;
            if (load_cnt == 4'd15) begin
              state_nxt = STREAM;
            end
          end
        end
        STREAM: begin
          if (w_ready) begin
            emit_acc = 1'b1;
            if (t == LAST_T) begin
              state_nxt = LOAD;
            end
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  // load_cnt is 4 bits, so it wraps to 0 by itself on the 16th accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_cnt <= 4'd0;
      t        <= 6'd0;
    end else if (flush) begin
      load_cnt <= 4'd0;
      t        <= 6'd0;
    end else begin
      if (load_acc) begin
        load_cnt <= load_cnt + 4'd1;
      end
      if (emit_acc) begin
        t <= (t == LAST_T) ? 6'd0 : t + 6'd1;
      end
    end
  end

  // Flush leaves the window as is; the next load overwrites every entry
  // before anything is streamed again.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= 32'd0;
      end
    end else if (!flush) begin
      if (load_acc) begin
        win[load_cnt] <= in_word;
      end else if (emit_acc) begin
        for (int i = 0; i < 15; i++) begin
          win[i] <= win[i+1];
        end
        win[15] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  localparam int R = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'd0;
  logic        w_valid;
  logic        w_ready = 1'b1;
  logic [31:0] w_out;
  logic [5:0]  w_index;
  logic        w_last;

  sha256_msg_schedule #(.ROUNDS(R)) dut (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_word (in_word),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_out   (w_out),
    .w_index (w_index),
    .w_last  (w_last)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_last = 0;
  bit rnd_rdy = 1'b0;

  logic [31:0] blk  [16];
  logic [31:0] wexp [64];
  logic [31:0] exp_q [$];
  int          exp_idx = 0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook recurrence over the whole array (not a sliding window).
  task automatic build_model();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) wexp[i] = blk[i];
      else wexp[i] = (ror(wexp[i-2], 17) ^ ror(wexp[i-2], 19) ^ (wexp[i-2] >> 10))
                   + wexp[i-7]
                   + (ror(wexp[i-15], 7) ^ ror(wexp[i-15], 18) ^ (wexp[i-15] >> 3))
                   + wexp[i-16];
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_expect();
    exp_q.delete();
    exp_idx = 0;
  endtask

  // w_ready driver: always 1, or a fair coin per cycle.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      w_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Compare process: checks every handshake against the model queue and
  // that outputs hold during every stalled cycle.
  logic [31:0] p_out;
  logic [5:0]  p_idx;
  logic        p_last;
  bit          have_prev = 1'b0;

  always @(negedge clock) begin
    if (!reset || flush) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        total++;
        if (!(w_valid && w_out == p_out && w_index == p_idx && w_last == p_last)) begin
          bad++;
          $display("FAIL stall_hold: got v=%b %h/%0d/%b expected %h/%0d/%b",
                   w_valid, w_out, w_index, w_last, p_out, p_idx, p_last);
        end
      end
      have_prev = w_valid && !w_ready;
      p_out = w_out; p_idx = w_index; p_last = w_last;
      if (w_valid && w_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h idx %0d expected none", w_out, w_index);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (w_out !== e || w_index !== 6'(exp_idx) || w_last !== (exp_idx == R - 1)) begin
            bad++;
            $display("FAIL stream_word: got %h idx %0d last %b expected %h idx %0d last %b",
                     w_out, w_index, w_last, e, exp_idx, (exp_idx == R - 1));
          end
          exp_idx++;
        end
        if (w_last) n_last++;
      end
    end
  end

  task automatic send_block(input bit gaps);
    build_model();
    for (int i = 0; i < R; i++) exp_q.push_back(wexp[i]);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        while ($urandom % 3 == 0) begin
          in_valid = 1'b0;
          @(posedge clock); #1;
        end
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("first_w_valid", 32'(w_valid), 32'd1);
    check("first_w_index", 32'(w_index), 32'd0);
    check("stream_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(posedge clock); #2;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
    end
    check({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({name, "_w_valid_after"}, 32'(w_valid), 32'd0);
  endtask

  task automatic wait_index(input int idx);
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clock); #1;
      if (w_valid && w_index == 6'(idx)) break;
    end
    check("reach_index", 32'(w_index), 32'(idx));
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  initial begin
    int lasts;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_w_out", w_out, 32'd0);
    check("rst_w_index", 32'(w_index), 32'd0);
    check("rst_w_last", 32'(w_last), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // "abc" padded block, with hand-computed expansion words pinning the model.
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    build_model();
    check("model_w16", wexp[16], 32'h61626380);
    check("model_w17", wexp[17], 32'h000F0000);
    lasts = n_last;
    send_block(1'b0);
    wait_done("abc");
    check("abc_one_last", 32'(n_last - lasts), 32'd1);
    clear_expect();

    // All-zero block.
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    lasts = n_last;
    send_block(1'b0);
    wait_done("zero");
    check("zero_one_last", 32'(n_last - lasts), 32'd1);
    clear_expect();

    // Random block, random w_ready and in_valid gaps.
    rand_block();
    rnd_rdy = 1'b1;
    send_block(1'b1);
    wait_done("random");
    clear_expect();
    rnd_rdy = 1'b0;

    // Two back-to-back blocks.
    rand_block();
    send_block(1'b0);
    wait_done("b2b_first");
    clear_expect();
    rand_block();
    send_block(1'b0);
    wait_done("b2b_second");
    clear_expect();

    // Reset mid-stream at index 20.
    rand_block();
    send_block(1'b0);
    wait_index(20);
    reset = 1'b0;
    #1;
    check("mid_rst_w_valid", 32'(w_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_w_index", 32'(w_index), 32'd0);
    check("mid_rst_w_out", w_out, 32'd0);
    @(posedge clock); #1;
    clear_expect();
    reset = 1'b1;
    @(posedge clock); #1;
    rand_block();
    send_block(1'b0);
    wait_done("after_reset");
    clear_expect();

    // Flush at load count 7; the word offered with flush must be dropped.
    rand_block();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_word = blk[i];
      @(posedge clock); #1;
    end
    flush = 1'b1; in_word = 32'hDEADBEEF;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_load_in_ready", 32'(in_ready), 32'd1);
    check("flush_load_w_valid", 32'(w_valid), 32'd0);
    rand_block();
    send_block(1'b0);

    // Flush at index 30 of that block.
    wait_index(30);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    clear_expect();
    check("flush_stream_in_ready", 32'(in_ready), 32'd1);
    check("flush_stream_w_valid", 32'(w_valid), 32'd0);
    check("flush_stream_w_index", 32'(w_index), 32'd0);
    rand_block();
    send_block(1'b0);
    wait_done("after_flush");
    clear_expect();

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
